// File: rtl/probe_trigger.sv
// probe_trigger: logic-analyzer probe front end.
// Synchronizes the asynchronous probe pins, divides the clock into a sample
// strobe and evaluates a programmable level/edge trigger. The single start
// pulse is issued on the same clock as the sample strobe of the triggering
// value, so the downstream capture block records that value as entry zero.
module probe_trigger #(
  parameter int LOG2_OF_NUMBER_OF_CHANNELS = 4,
  parameter int DIVIDER_WIDTH              = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        arm,
  input  logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] probeIn,
  input  logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] triggerMask,
  input  logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] triggerValue,
  input  logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] edgeMask,
  input  logic [DIVIDER_WIDTH-1:0]                     divider,
  output logic [(1 << LOG2_OF_NUMBER_OF_CHANNELS)-1:0] dataOut,
  output logic                                        sample,
  output logic                                        start,
  output logic                                        armed,
  output logic                                        triggered
);

  localparam int N = 1 << LOG2_OF_NUMBER_OF_CHANNELS;
  localparam logic [DIVIDER_WIDTH-1:0] ONE = {{(DIVIDER_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [N-1:0]             r_sync1;
  logic [N-1:0]             r_sync2;
  logic [N-1:0]             r_prev;
  logic [N-1:0]             r_data;
  logic [DIVIDER_WIDTH-1:0] r_count;
  logic                     r_sample;
  logic                     r_start;
  logic                     r_armed;
  logic                     r_triggered;

  logic                     w_tick;
  logic                     w_arm_idle;
  logic                     w_level;
  logic                     w_edge;
  logic                     w_cond;
  logic                     w_sample_d;
  logic                     w_start_d;
  logic                     w_armed_d;
  logic                     w_triggered_d;

  // ">=" rather than "==": lowering divider below the running count must
  // tick at once instead of wrapping through the whole counter range.
  assign w_tick     = (r_count >= divider);
  assign w_arm_idle = arm && (r_state == IDLE);

  // Trigger is judged on the synchronized value against the previous sample,
  // so edges are seen between consecutive samples, not consecutive clocks.
  assign w_level = (((r_sync2 ^ triggerValue) & triggerMask) == '0);
  assign w_edge  = (edgeMask == '0) || (((r_sync2 ^ r_prev) & edgeMask) != '0);
  assign w_cond  = w_level && w_edge;

  // Two-flop synchronizer on the probe pins plus the registered data output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_data  <= '0;
    end else begin
      r_sync1 <= probeIn;
      r_sync2 <= r_sync1;
      r_data  <= r_sync2;
    end
  end

  // Sample-rate divider; free-running in every state, restarted by arming.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (w_arm_idle || w_tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + ONE;
    end
  end

  // Previous-sample register used by the edge condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev <= '0;
    end else if (w_tick || w_arm_idle) begin
      r_prev <= r_sync2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic; TRIGGERED is sticky until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:      if (arm)              w_state_nxt = ARMED;
      ARMED:     if (w_tick && w_cond) w_state_nxt = TRIGGERED;
      TRIGGERED: w_state_nxt = TRIGGERED;
      default:   w_state_nxt = IDLE;
    endcase
  end

  // FSM output decode; start uses the pre-transition state so it lands with
  // the sample strobe of the triggering value.
  always_comb begin
    w_sample_d    = w_tick && (r_state != IDLE);
    w_start_d     = w_tick && (r_state == ARMED) && w_cond;
    w_armed_d     = (w_state_nxt == ARMED);
    w_triggered_d = (w_state_nxt == TRIGGERED);
  end

  // Registered strobes and state flags, aligned with dataOut.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sample    <= 1'b0;
      r_start     <= 1'b0;
      r_armed     <= 1'b0;
      r_triggered <= 1'b0;
    end else begin
      r_sample    <= w_sample_d;
      r_start     <= w_start_d;
      r_armed     <= w_armed_d;
      r_triggered <= w_triggered_d;
    end
  end

  assign dataOut   = r_data;
  assign sample    = r_sample;
  assign start     = r_start;
  assign armed     = r_armed;
  assign triggered = r_triggered;

endmodule
